// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan-chain transmit driver.
// Chain addresses match the select decode inside ScanTop.
package scan_pkg;

    localparam int SCAN_ADDR_W    = 12;
    localparam int SCAN_PAYLOAD_W = 169;
    localparam int SCAN_PRE_IDLE  = 1;
    localparam int SCAN_POST_IDLE = 2;

    localparam logic [SCAN_ADDR_W-1:0] SCAN_ADDR_OSC     = 12'd1;
    localparam logic [SCAN_ADDR_W-1:0] SCAN_ADDR_RF_ANLG = 12'd2;
    localparam logic [SCAN_ADDR_W-1:0] SCAN_ADDR_SUPPLY  = 12'd3;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ADDR,
        DATA,
        POST
    } scan_state_e;

endpackage

// File: rtl/scan_piso_shift.sv
// Parallel-load, MSB-first shift register; msb_o is the bit to transmit next.
// Load takes priority over shift; synchronous active-high reset.
module scan_piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] shift_q, shift_d;

    always_comb begin
        shift_d = shift_q;
        if (load_i) begin
            shift_d = load_data_i;
        end else if (shift_i) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign msb_o = shift_q[WIDTH-1];

endmodule

// File: rtl/scan_chain_driver.sv
// Frames one {address, payload} request onto scan_en/scan_in for ScanTop.
// Optional readback of scan_out during DATA is enabled by SCAN_READBACK_EN.
//
//   state | meaning
//   IDLE  | ready for a request, scan_en low
//   PRE   | PRE_IDLE quiet cycles before the address
//   ADDR  | address bits, MSB first, scan_en high
//   DATA  | payload bits, MSB first, scan_en high
//   POST  | POST_IDLE quiet cycles, done in the last one
module scan_chain_driver
    import scan_pkg::*;
#(
    parameter int ADDR_W    = SCAN_ADDR_W,
    parameter int PAYLOAD_W = SCAN_PAYLOAD_W,
    parameter int PRE_IDLE  = SCAN_PRE_IDLE,
    parameter int POST_IDLE = SCAN_POST_IDLE
) (
    input  logic                 scan_clk,
    input  logic                 scan_reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [PAYLOAD_W-1:0] req_payload,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 busy,
    output logic                 done,
    output logic [PAYLOAD_W-1:0] rd_data,
    output logic                 rd_valid
);

    localparam int CNT_W = $clog2(PAYLOAD_W + 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(PRE_IDLE - 1);
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(PAYLOAD_W - 1);
    localparam logic [CNT_W-1:0] CNT_POST = CNT_W'(POST_IDLE - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             addr_msb, data_msb;
    logic             shift_addr, shift_data;
    logic             scan_en_q, scan_en_d;
    logic             scan_in_q, scan_in_d;
    logic             done_q, done_d;

    assign accept = req_valid && (state_q == IDLE);

    scan_piso_shift #(.WIDTH(ADDR_W)) u_addr_shift (
        .clk_i       (scan_clk),
        .rst_i       (scan_reset),
        .load_i      (accept),
        .load_data_i (req_addr),
        .shift_i     (shift_addr),
        .msb_o       (addr_msb)
    );

    scan_piso_shift #(.WIDTH(PAYLOAD_W)) u_data_shift (
        .clk_i       (scan_clk),
        .rst_i       (scan_reset),
        .load_i      (accept),
        .load_data_i (req_payload),
        .shift_i     (shift_data),
        .msb_o       (data_msb)
    );

    // Shared down-counter: reloaded with (length-1) on entry, phase ends at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PRE;
                    cnt_d   = CNT_PRE;
                end
            end
            PRE: begin
                if (cnt_q == '0) begin
                    state_d = ADDR;
                    cnt_d   = CNT_ADDR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ADDR: begin
                if (cnt_q == '0) begin
                    state_d = DATA;
                    cnt_d   = CNT_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    state_d = POST;
                    cnt_d   = CNT_POST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            POST: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state, so they line up with state_q.
    always_comb begin
        shift_addr = (state_d == ADDR);
        shift_data = (state_d == DATA);
        scan_en_d  = shift_addr || shift_data;
        scan_in_d  = 1'b0;
        if (shift_addr) begin
            scan_in_d = addr_msb;
        end else if (shift_data) begin
            scan_in_d = data_msb;
        end
        done_d = (state_d == POST) && (cnt_d == '0);
    end

    always_ff @(posedge scan_clk) begin
        if (scan_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            scan_en_q <= 1'b0;
            scan_in_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scan_en_q <= scan_en_d;
            scan_in_q <= scan_in_d;
            done_q    <= done_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign scan_en   = scan_en_q;
    assign scan_in   = scan_in_q;
    assign done      = done_q;

`ifdef SCAN_READBACK_EN
    logic [PAYLOAD_W-1:0] rd_shift_q, rd_shift_d;
    logic [PAYLOAD_W-1:0] rd_data_q;
    logic                 rd_valid_q;

    // Forwarding the in-flight shift keeps the last bit when POST_IDLE is 1.
    always_comb begin
        rd_shift_d = rd_shift_q;
        if (state_q == DATA) begin
            rd_shift_d = {rd_shift_q[PAYLOAD_W-2:0], scan_out};
        end
    end

    always_ff @(posedge scan_clk) begin
        if (scan_reset) begin
            rd_shift_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_shift_q <= rd_shift_d;
            rd_valid_q <= done_d;
            if (done_d) begin
                rd_data_q <= rd_shift_d;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`else
    logic unused_scan_out;

    assign unused_scan_out = scan_out;
    assign rd_data         = '0;
    assign rd_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_driver.sv
// Directed bench for scan_chain_driver with scan_out looped back to scan_in.
// Cycle n after an accept edge is observed at the n-th falling edge after it.
module tb_scan_chain_driver;

    logic         scan_clk;
    logic         scan_reset;
    logic         req_valid;
    logic         req_ready;
    logic [11:0]  req_addr;
    logic [168:0] req_payload;
    logic         scan_en;
    logic         scan_in;
    logic         scan_out;
    logic         busy;
    logic         done;
    logic [168:0] rd_data;
    logic         rd_valid;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_pulses = 0;
    int rv_pulses = 0;

    scan_chain_driver dut (
        .scan_clk    (scan_clk),
        .scan_reset  (scan_reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_payload (req_payload),
        .scan_en     (scan_en),
        .scan_in     (scan_in),
        .scan_out    (scan_out),
        .busy        (busy),
        .done        (done),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid)
    );

    assign scan_out = scan_in;

    initial scan_clk = 1'b0;
    always #5 scan_clk = ~scan_clk;

    always @(negedge scan_clk) begin
        if (done === 1'b1) done_pulses++;
        if (rd_valid === 1'b1) rv_pulses++;
    end

    // Sends one request (accepted on the next rising edge) and records the serial frame.
    task automatic run_frame(input logic [11:0] a, input logic [168:0] p,
                             input bit hold, input logic [11:0] a2, input logic [168:0] p2,
                             output logic [180:0] stream, output int nbits, output int en_start,
                             output int done_at, output int ready_hi, output int stray,
                             output logic rv_at_done, output logic [168:0] rd_at_done);
        bit finished;
        stream = '0; nbits = 0; en_start = -1; done_at = -1;
        ready_hi = 0; stray = 0; rv_at_done = 1'b0; rd_at_done = '0;
        req_valid = 1'b1; req_addr = a; req_payload = p;
        @(posedge scan_clk);
        #1;
        if (hold) begin
            req_addr = a2; req_payload = p2;
        end else begin
            req_valid = 1'b0;
        end
        finished = 1'b0;
        for (int n = 1; n <= 300 && !finished; n++) begin
            @(negedge scan_clk);
            if (req_ready === 1'b1) ready_hi++;
            if (scan_en === 1'b1) begin
                if (en_start < 0) en_start = n;
                stream = {stream[179:0], scan_in};
                nbits++;
            end else if (scan_in !== 1'b0) begin
                stray++;
            end
            if (done === 1'b1) begin
                done_at = n;
                rv_at_done = rd_valid;
                rd_at_done = rd_data;
                finished = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        scan_reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_payload = '0;
        repeat (3) @(posedge scan_clk);
        @(negedge scan_clk);
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready); else pass_cnt++;
        total_cnt++; if (scan_en !== 1'b0) $display("FAIL reset_scan_en got=%b exp=0", scan_en); else pass_cnt++;
        total_cnt++; if (scan_in !== 1'b0) $display("FAIL reset_scan_in got=%b exp=0", scan_in); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0 || rd_data !== '0)
            $display("FAIL reset_rd got=%b/%h exp=0/0", rd_valid, rd_data); else pass_cnt++;
        scan_reset = 1'b0;
        @(negedge scan_clk);
    endtask

    task automatic test_single_frame();
        logic [180:0] s; logic [168:0] rd; logic rv;
        int nb, es, da, rh, st;
        run_frame(12'd3, 169'd804937, 1'b0, '0, '0, s, nb, es, da, rh, st, rv, rd);
        total_cnt++; if (s[180:169] !== 12'b000000000011)
            $display("FAIL frame_addr got=%b exp=000000000011", s[180:169]); else pass_cnt++;
        total_cnt++; if (s[168:0] !== 169'd804937)
            $display("FAIL frame_payload got=%0d exp=804937", s[168:0]); else pass_cnt++;
        total_cnt++; if (nb !== 181) $display("FAIL frame_len got=%0d exp=181", nb); else pass_cnt++;
        total_cnt++; if (es !== 2) $display("FAIL frame_en_start got=%0d exp=2", es); else pass_cnt++;
        total_cnt++; if (da !== 184) $display("FAIL frame_latency got=%0d exp=184", da); else pass_cnt++;
        total_cnt++; if (rh !== 0 || st !== 0)
            $display("FAIL frame_ready_stray got=%0d/%0d exp=0/0", rh, st); else pass_cnt++;
        @(negedge scan_clk);
        total_cnt++; if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL frame_after_done got=done%b ready%b busy%b exp=0/1/0", done, req_ready, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [180:0] s; logic [168:0] rd; logic rv;
        int nb, es, da, rh, st;
        logic [168:0] p_osc, p_rf, p_sup;
        logic [52:0]  osc_chain;
        logic [168:0] rf_chain;
        logic [19:0]  sup_chain;
        p_osc = {41'h0_0F0F_0F0F_0, 128'hCAFE_F00D_0000_0000_0015_5555_5555_5555};
        p_rf  = {41'h1_2345_6789_A, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        p_sup = {41'h1_FFFF_FFFF_F, 128'hDEAD_BEEF_0000_0000_0000_0000_000A_5A5A};
        osc_chain = '0; rf_chain = '0; sup_chain = '0;

        run_frame(12'd1, p_osc, 1'b0, '0, '0, s, nb, es, da, rh, st, rv, rd);
        if (s[180:169] == 12'd1) osc_chain = s[52:0];
        total_cnt++; if (da !== 184) $display("FAIL b2b_osc_latency got=%0d exp=184", da); else pass_cnt++;
        @(negedge scan_clk);
        run_frame(12'd2, p_rf, 1'b0, '0, '0, s, nb, es, da, rh, st, rv, rd);
        if (s[180:169] == 12'd2) rf_chain = s[168:0];
        total_cnt++; if (es !== 2 || da !== 184)
            $display("FAIL b2b_rf_timing got=%0d/%0d exp=2/184", es, da); else pass_cnt++;
        @(negedge scan_clk);
        run_frame(12'd3, p_sup, 1'b0, '0, '0, s, nb, es, da, rh, st, rv, rd);
        if (s[180:169] == 12'd3) sup_chain = s[19:0];
        total_cnt++; if (es !== 2 || da !== 184)
            $display("FAIL b2b_sup_timing got=%0d/%0d exp=2/184", es, da); else pass_cnt++;

        total_cnt++; if (osc_chain !== 53'h15_5555_5555_5555)
            $display("FAIL chain_osc got=%h exp=155555555555555", osc_chain); else pass_cnt++;
        total_cnt++; if (rf_chain !== {41'h1_2345_6789_A, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210})
            $display("FAIL chain_rf got=%h", rf_chain); else pass_cnt++;
        total_cnt++; if (sup_chain !== 20'hA5A5A)
            $display("FAIL chain_supply got=%h exp=a5a5a", sup_chain); else pass_cnt++;
        @(negedge scan_clk);
    endtask

    task automatic test_busy_ignore();
        logic [180:0] s; logic [168:0] rd; logic rv;
        int nb, es, da, rh, st;
        run_frame(12'hA5C, 169'h1_5555, 1'b1, 12'h3C3, 169'h0_ABCD_EF00, s, nb, es, da, rh, st, rv, rd);
        total_cnt++; if (rh !== 0) $display("FAIL busy_ready_high got=%0d cycles exp=0", rh); else pass_cnt++;
        total_cnt++; if (s !== {12'hA5C, 169'h1_5555})
            $display("FAIL busy_frame_bits got=%h exp=%h", s, {12'hA5C, 169'h1_5555}); else pass_cnt++;
        @(negedge scan_clk);
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL busy_ready_after_done got=%b exp=1", req_ready); else pass_cnt++;
        run_frame(12'h3C3, 169'h0_ABCD_EF00, 1'b0, '0, '0, s, nb, es, da, rh, st, rv, rd);
        total_cnt++; if (es !== 2 || s !== {12'h3C3, 169'h0_ABCD_EF00})
            $display("FAIL busy_second_frame got=start%0d %h", es, s); else pass_cnt++;
        @(negedge scan_clk);
    endtask

    task automatic test_mid_reset();
        int d0, r0;
        req_valid = 1'b1; req_addr = 12'd2; req_payload = {169{1'b1}};
        @(posedge scan_clk);
        #1 req_valid = 1'b0;
        repeat (64) @(negedge scan_clk);
        total_cnt++; if (scan_en !== 1'b1 || busy !== 1'b1)
            $display("FAIL midrst_in_data got=en%b busy%b exp=1/1", scan_en, busy); else pass_cnt++;
        d0 = done_pulses; r0 = rv_pulses;
        scan_reset = 1'b1;
        @(negedge scan_clk);
        total_cnt++; if (scan_en !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL midrst_state got=en%b busy%b ready%b exp=0/0/1", scan_en, busy, req_ready);
        else pass_cnt++;
        scan_reset = 1'b0;
        repeat (200) @(negedge scan_clk);
        total_cnt++; if (done_pulses !== d0 || rv_pulses !== r0)
            $display("FAIL midrst_no_done got=%0d/%0d extra pulses exp=0/0", done_pulses - d0, rv_pulses - r0);
        else pass_cnt++;
        total_cnt++; if (rd_data !== '0) $display("FAIL midrst_rd_data got=%h exp=0", rd_data); else pass_cnt++;
    endtask

    task automatic test_readback();
        logic [180:0] s; logic [168:0] rd; logic rv;
        int nb, es, da, rh, st, r0;
        logic [168:0] p;
        p = {41'h0_DEAD_BEEF_1, 128'h8000_0000_0000_0001_F0F0_F0F0_1234_5678};
        r0 = rv_pulses;
        run_frame(12'd2, p, 1'b0, '0, '0, s, nb, es, da, rh, st, rv, rd);
        @(negedge scan_clk);
`ifdef SCAN_READBACK_EN
        total_cnt++; if (rv !== 1'b1) $display("FAIL rb_valid_at_done got=%b exp=1", rv); else pass_cnt++;
        total_cnt++; if (rd !== {41'h0_DEAD_BEEF_1, 128'h8000_0000_0000_0001_F0F0_F0F0_1234_5678})
            $display("FAIL rb_data got=%h", rd); else pass_cnt++;
        total_cnt++; if (rv_pulses - r0 !== 1) $display("FAIL rb_pulse_count got=%0d exp=1", rv_pulses - r0); else pass_cnt++;
        total_cnt++; if (rd_valid !== 1'b0 || rd_data !== p)
            $display("FAIL rb_hold got=%b/%h", rd_valid, rd_data); else pass_cnt++;
`else
        total_cnt++; if (rv_pulses !== 0) $display("FAIL rb_off_valid got=%0d pulses exp=0", rv_pulses); else pass_cnt++;
        total_cnt++; if (rd !== '0 || rd_data !== '0) $display("FAIL rb_off_data got=%h exp=0", rd_data); else pass_cnt++;
        total_cnt++; if (da !== 184) $display("FAIL rb_off_latency got=%0d exp=184", da); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        test_readback();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
